// File: rtl/alu_lockstep_cmp_if.sv
// Sample/result bundle for the lockstep ALU checker.
// The bench or host drives it as master; the checker is the slave.
interface alu_lockstep_cmp_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 8
);
  logic                   valid_i;
  logic [LANES*WIDTH-1:0] a_i;
  logic [LANES*WIDTH-1:0] b_i;
  logic [LANES*2-1:0]     sel_i;
  logic                   clr_i;
  logic                   valid_o;
  logic [LANES*WIDTH-1:0] result_o;
  logic [LANES-1:0]       carry_o;
  logic [WIDTH-1:0]       diff_o;
  logic                   carry_diff_o;
  logic [WIDTH-1:0]       voted_o;
  logic                   mismatch_o;
  logic [CNT_W-1:0]       err_cnt_o;
  logic                   fault_o;

  modport master (
    output valid_i, a_i, b_i, sel_i, clr_i,
    input  valid_o, result_o, carry_o, diff_o, carry_diff_o, voted_o, mismatch_o, err_cnt_o,
           fault_o
  );

  modport slave (
    input  valid_i, a_i, b_i, sel_i, clr_i,
    output valid_o, result_o, carry_o, diff_o, carry_diff_o, voted_o, mismatch_o, err_cnt_o,
           fault_o
  );
endinterface

// File: rtl/alu_lockstep_cmp.sv
// Lockstep ALU checker: LANES parallel ALUs, two-stage pipeline, cross-compare,
// saturating mismatch counter and a sticky fault FSM.
module alu_lockstep_cmp #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LANES    = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned FAULT_TH = 3
) (
  input logic               wb_clk_i,
  input logic               wb_rst_ni,
  alu_lockstep_cmp_if.slave bus_io
);

  typedef enum logic [1:0] {StOk, StSuspect, StFault} state_e;

  // Returns {carry, result}; SUB carry means "no borrow".
  function automatic logic [WIDTH:0] alu_op(input logic [1:0] sel, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sub;
    sub = {1'b0, a} - {1'b0, b};
    unique case (sel)
      2'b00:   alu_op = {1'b0, a} + {1'b0, b};
      2'b01:   alu_op = {~sub[WIDTH], sub[WIDTH-1:0]};
      2'b10:   alu_op = {1'b0, a & b};
      default: alu_op = {1'b0, a ^ b};
    endcase
  endfunction

  logic [LANES-1:0][WIDTH-1:0] res_d, res_q;
  logic [LANES-1:0]            car_d, car_q;
  logic                        s1_valid_d, s1_valid_q;
  logic                        valid_d, valid_q;
  logic [WIDTH-1:0]            diff_d, diff_q, voted_d, voted_q;
  logic                        cdiff_d, cdiff_q, mism_d, mism_q;
  logic [CNT_W-1:0]            cnt_d, cnt_q;
  logic [3:0]                  run_d, run_q;
  state_e                      state_d, state_q;
  logic                        fault_d, fault_q;
  logic [WIDTH-1:0]            vote_now;
  logic                        mism_now;

  always_comb begin
    res_d      = res_q;
    car_d      = car_q;
    s1_valid_d = bus_io.valid_i;
    if (bus_io.valid_i) begin
      for (int k = 0; k < LANES; k++) begin
        {car_d[k], res_d[k]} = alu_op(bus_io.sel_i[2*k +: 2], bus_io.a_i[k*WIDTH +: WIDTH],
                                      bus_io.b_i[k*WIDTH +: WIDTH]);
      end
    end
  end

  if (LANES == 3) begin : g_vote
    assign vote_now = (res_q[0] & res_q[1]) | (res_q[0] & res_q[2]) | (res_q[1] & res_q[2]);
    // Carries disagree somewhere iff they are neither all 0 nor all 1.
    assign mism_now = (res_q[0] != res_q[1]) || (res_q[0] != res_q[2]) ||
                      (car_q != '0 && car_q != '1);
  end else begin : g_cmp
    assign vote_now = res_q[0];
    assign mism_now = (res_q[0] != res_q[1]) || (car_q[0] != car_q[1]);
  end

  always_comb begin
    valid_d = s1_valid_q;
    diff_d  = diff_q;
    cdiff_d = cdiff_q;
    voted_d = voted_q;
    mism_d  = mism_q;
    if (s1_valid_q) begin
      diff_d  = res_q[0] ^ res_q[1];
      cdiff_d = car_q[0] ^ car_q[1];
      voted_d = vote_now;
      mism_d  = mism_now;
    end
  end

  // Counter and FSM consume the sample entering stage 2; clear overrides it.
  always_comb begin
    cnt_d   = cnt_q;
    run_d   = run_q;
    state_d = state_q;
    if (bus_io.clr_i) begin
      cnt_d   = '0;
      run_d   = '0;
      state_d = StOk;
    end else if (s1_valid_q) begin
      if (mism_now && cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        StOk: begin
          if (mism_now) begin
            run_d   = 4'd1;
            state_d = (FAULT_TH <= 1) ? StFault : StSuspect;
          end
        end
        StSuspect: begin
          if (mism_now) begin
            run_d = run_q + 4'd1;
            if ({28'd0, run_q} + 32'd1 >= FAULT_TH) state_d = StFault;
          end else begin
            run_d   = '0;
            state_d = StOk;
          end
        end
        StFault: begin
        end
        default: begin
          run_d   = '0;
          state_d = StOk;
        end
      endcase
    end
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      res_q      <= '0;
      car_q      <= '0;
      s1_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      diff_q     <= '0;
      cdiff_q    <= 1'b0;
      voted_q    <= '0;
      mism_q     <= 1'b0;
    end else begin
      res_q      <= res_d;
      car_q      <= car_d;
      s1_valid_q <= s1_valid_d;
      valid_q    <= valid_d;
      diff_q     <= diff_d;
      cdiff_q    <= cdiff_d;
      voted_q    <= voted_d;
      mism_q     <= mism_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q   <= '0;
      run_q   <= '0;
      state_q <= StOk;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign bus_io.valid_o      = valid_q;
  assign bus_io.result_o     = res_q;
  assign bus_io.carry_o      = car_q;
  assign bus_io.diff_o       = diff_q;
  assign bus_io.carry_diff_o = cdiff_q;
  assign bus_io.voted_o      = voted_q;
  assign bus_io.mismatch_o   = mism_q;
  assign bus_io.err_cnt_o    = cnt_q;
  assign bus_io.fault_o      = fault_q;

endmodule

// File: tb/tb_alu_lockstep_cmp.sv
// Bench for alu_lockstep_cmp: a 2-lane (TH=3, 8-bit counter) and a 3-lane (TH=1, 2-bit
// counter) instance, checked every cycle against a sample-level model plus literal checks.
module tb_alu_lockstep_cmp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_lockstep_cmp_if #(.WIDTH(4), .LANES(2), .CNT_W(8)) bus0 ();
  alu_lockstep_cmp_if #(.WIDTH(4), .LANES(3), .CNT_W(2)) bus1 ();

  alu_lockstep_cmp #(.WIDTH(4), .LANES(2), .CNT_W(8), .FAULT_TH(3)) u_dut0 (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus_io   (bus0)
  );

  alu_lockstep_cmp #(.WIDTH(4), .LANES(3), .CNT_W(2), .FAULT_TH(1)) u_dut1 (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus_io   (bus1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance: last captured lane results and last reported sample.
  logic       m_s1v[2];
  logic [3:0] m_res[2][3];
  logic       m_car[2][3];
  logic       m_v[2];
  logic [3:0] m_diff[2];
  logic [3:0] m_vote[2];
  logic       m_cd[2];
  logic       m_mis[2];
  logic       m_fault[2];
  int         m_cnt[2];
  int         m_run[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_alu(input logic [1:0] op, input int a, input int b);
    int   r;
    logic c;
    case (op)
      2'd0:    begin r = a + b; c = (r > 15); r = r % 16; end
      2'd1:    begin r = (a - b + 16) % 16; c = (a >= b); end
      2'd2:    begin r = a & b; c = 1'b0; end
      default: begin r = a ^ b; c = 1'b0; end
    endcase
    return {c, 4'(r)};
  endfunction

  task automatic model_reset(input int i);
    m_s1v[i] = 1'b0; m_v[i] = 1'b0; m_diff[i] = '0; m_vote[i] = '0; m_cd[i] = 1'b0;
    m_mis[i] = 1'b0; m_fault[i] = 1'b0; m_cnt[i] = 0; m_run[i] = 0;
    for (int k = 0; k < 3; k++) begin
      m_res[i][k] = '0;
      m_car[i][k] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input int lanes, input int cmax, input int th,
                            input logic v, input logic [11:0] a, input logic [11:0] b,
                            input logic [5:0] sel, input logic clr);
    logic mis;
    int   ones;
    mis = 1'b0;
    if (m_s1v[i]) begin
      for (int p = 0; p < lanes; p++)
        for (int q = p + 1; q < lanes; q++)
          if (m_res[i][p] != m_res[i][q] || m_car[i][p] != m_car[i][q]) mis = 1'b1;
      for (int j = 0; j < 4; j++) begin
        ones = int'(m_res[i][0][j]) + int'(m_res[i][1][j]) + int'(m_res[i][2][j]);
        m_vote[i][j] = (lanes == 3) ? (ones >= 2) : m_res[i][0][j];
      end
      m_diff[i] = m_res[i][0] ^ m_res[i][1];
      m_cd[i]   = m_car[i][0] ^ m_car[i][1];
      m_mis[i]  = mis;
    end
    m_v[i] = m_s1v[i];
    if (clr) begin
      m_cnt[i] = 0; m_run[i] = 0; m_fault[i] = 1'b0;
    end else if (m_s1v[i]) begin
      if (mis) begin
        if (m_cnt[i] < cmax) m_cnt[i]++;
        m_run[i]++;
        if (m_run[i] >= th) m_fault[i] = 1'b1;
      end else begin
        m_run[i] = 0;
      end
    end
    if (v) begin
      for (int k = 0; k < lanes; k++)
        {m_car[i][k], m_res[i][k]} = ref_alu(sel[2*k +: 2], int'(a[4*k +: 4]), int'(b[4*k +: 4]));
    end
    m_s1v[i] = v;
  endtask

  task automatic check_dut0;
    chk("u0.valid_o", 32'(bus0.valid_o), 32'(m_v[0]));
    chk("u0.result_o", 32'(bus0.result_o), 32'({m_res[0][1], m_res[0][0]}));
    chk("u0.carry_o", 32'(bus0.carry_o), 32'({m_car[0][1], m_car[0][0]}));
    chk("u0.diff_o", 32'(bus0.diff_o), 32'(m_diff[0]));
    chk("u0.carry_diff_o", 32'(bus0.carry_diff_o), 32'(m_cd[0]));
    chk("u0.voted_o", 32'(bus0.voted_o), 32'(m_vote[0]));
    chk("u0.mismatch_o", 32'(bus0.mismatch_o), 32'(m_mis[0]));
    chk("u0.err_cnt_o", 32'(bus0.err_cnt_o), 32'(m_cnt[0]));
    chk("u0.fault_o", 32'(bus0.fault_o), 32'(m_fault[0]));
  endtask

  task automatic check_dut1;
    chk("u1.valid_o", 32'(bus1.valid_o), 32'(m_v[1]));
    chk("u1.result_o", 32'(bus1.result_o), 32'({m_res[1][2], m_res[1][1], m_res[1][0]}));
    chk("u1.carry_o", 32'(bus1.carry_o), 32'({m_car[1][2], m_car[1][1], m_car[1][0]}));
    chk("u1.diff_o", 32'(bus1.diff_o), 32'(m_diff[1]));
    chk("u1.carry_diff_o", 32'(bus1.carry_diff_o), 32'(m_cd[1]));
    chk("u1.voted_o", 32'(bus1.voted_o), 32'(m_vote[1]));
    chk("u1.mismatch_o", 32'(bus1.mismatch_o), 32'(m_mis[1]));
    chk("u1.err_cnt_o", 32'(bus1.err_cnt_o), 32'(m_cnt[1]));
    chk("u1.fault_o", 32'(bus1.fault_o), 32'(m_fault[1]));
  endtask

  // Inputs only change on negedge, so they are still the captured values at posedge+1.
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0, 2, 255, 3, bus0.valid_i, {4'h0, bus0.a_i}, {4'h0, bus0.b_i},
                   {2'b00, bus0.sel_i}, bus0.clr_i);
        model_step(1, 3, 3, 1, bus1.valid_i, bus1.a_i, bus1.b_i, bus1.sel_i, bus1.clr_i);
      end
      check_dut0();
      check_dut1();
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drv0(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] sel, input logic clr);
    bus0.valid_i = v; bus0.a_i = a; bus0.b_i = b; bus0.sel_i = sel; bus0.clr_i = clr;
  endtask

  task automatic drv1(input logic v, input logic [11:0] a, input logic [11:0] b,
                      input logic [5:0] sel, input logic clr);
    bus1.valid_i = v; bus1.a_i = a; bus1.b_i = b; bus1.sel_i = sel; bus1.clr_i = clr;
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } vec2_t;

  vec2_t t4_seq[6];
  vec2_t mix[4];

  initial begin
    vec2_t mis_v, ok_v;
    mis_v = '{a: 8'h33, b: 8'h54, sel: 4'b0101};
    ok_v  = '{a: 8'h99, b: 8'h88, sel: 4'b0000};
    t4_seq = '{mis_v, mis_v, ok_v, mis_v, mis_v, mis_v};
    mix = '{'{a: 8'h55, b: 8'h55, sel: 4'b0101}, '{a: 8'h1F, b: 8'h11, sel: 4'b0000},
            '{a: 8'hC3, b: 8'hA5, sel: 4'b1010}, '{a: 8'h6A, b: 8'h35, sel: 4'b0111}};

    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst.u0.valid_o", 32'(bus0.valid_o), 32'd0);
    chk("rst.u0.err_cnt_o", 32'(bus0.err_cnt_o), 32'd0);
    chk("rst.u1.fault_o", 32'(bus1.fault_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD 9+8 in both lanes: result 1, carry 1, clean compare two cycles later.
    drv0(1, ok_v.a, ok_v.b, ok_v.sel, 0);
    tick();
    drv0(0, 0, 0, 0, 0);
    chk("t2.result_o", 32'(bus0.result_o), 32'h11);
    chk("t2.carry_o", 32'(bus0.carry_o), 32'h3);
    chk("t2.valid_o_n1", 32'(bus0.valid_o), 32'd0);
    tick();
    chk("t2.valid_o_n2", 32'(bus0.valid_o), 32'd1);
    chk("t2.mismatch_o", 32'(bus0.mismatch_o), 32'd0);
    chk("t2.diff_o", 32'(bus0.diff_o), 32'd0);

    // SUB 3-4 vs 3-5.
    drv0(1, mis_v.a, mis_v.b, mis_v.sel, 0);
    tick();
    drv0(0, 0, 0, 0, 0);
    chk("t3.result_o", 32'(bus0.result_o), 32'hEF);
    chk("t3.carry_o", 32'(bus0.carry_o), 32'h0);
    tick();
    chk("t3.diff_o", 32'(bus0.diff_o), 32'h1);
    chk("t3.mismatch_o", 32'(bus0.mismatch_o), 32'd1);
    chk("t3.err_cnt_o", 32'(bus0.err_cnt_o), 32'd1);

    // mis, mis, match, mis x3 with threshold 3.
    drv0(0, 0, 0, 0, 1);
    tick();
    foreach (t4_seq[i]) begin
      drv0(1, t4_seq[i].a, t4_seq[i].b, t4_seq[i].sel, 0);
      tick();
    end
    drv0(0, 0, 0, 0, 0);
    chk("t4.fault_after5", 32'(bus0.fault_o), 32'd0);
    chk("t4.cnt_after5", 32'(bus0.err_cnt_o), 32'd4);
    tick();
    chk("t4.fault_after6", 32'(bus0.fault_o), 32'd1);
    chk("t4.cnt_after6", 32'(bus0.err_cnt_o), 32'd5);
    drv0(1, ok_v.a, ok_v.b, ok_v.sel, 0);
    tick();
    drv0(0, 0, 0, 0, 0);
    tick();
    chk("t4.fault_sticky", 32'(bus0.fault_o), 32'd1);
    drv0(0, 0, 0, 0, 1);
    tick();
    drv0(0, 0, 0, 0, 0);
    chk("t4.clr_cnt", 32'(bus0.err_cnt_o), 32'd0);
    chk("t4.clr_fault", 32'(bus0.fault_o), 32'd0);

    // Carry-only disagreement: 8+8 -> 0,c=1 against 0^0 -> 0,c=0.
    drv0(1, 8'h08, 8'h08, 4'b1100, 0);
    repeat (2) tick();
    drv0(0, 0, 0, 0, 0);
    chk("carry_only.diff_o", 32'(bus0.diff_o), 32'd0);
    chk("carry_only.carry_diff_o", 32'(bus0.carry_diff_o), 32'd1);
    chk("carry_only.mismatch_o", 32'(bus0.mismatch_o), 32'd1);
    foreach (mix[i]) begin
      drv0(1, mix[i].a, mix[i].b, mix[i].sel, 0);
      tick();
    end
    drv0(0, 0, 0, 0, 0);
    repeat (3) tick();

    // 3 lanes: lane2 XOR F^0 outvoted by two AND F&6 lanes.
    drv1(1, 12'hFFF, 12'h066, 6'b111010, 0);
    tick();
    drv1(0, 0, 0, 0, 0);
    chk("t5.result_o", 32'(bus1.result_o), 32'hF66);
    tick();
    chk("t5.voted_o", 32'(bus1.voted_o), 32'h6);
    chk("t5.mismatch_o", 32'(bus1.mismatch_o), 32'd1);
    chk("t5.diff_o", 32'(bus1.diff_o), 32'd0);
    chk("t5.fault_th1", 32'(bus1.fault_o), 32'd1);
    drv1(1, 12'h33C, 12'h000, 6'b111111, 0);
    tick();
    drv1(1, 12'h777, 12'h222, 6'b000000, 0);
    tick();
    drv1(0, 0, 0, 0, 0);
    chk("vote_lane0_out.voted_o", 32'(bus1.voted_o), 32'h3);
    chk("vote_lane0_out.diff_o", 32'(bus1.diff_o), 32'hF);
    tick();
    chk("l3_match.voted_o", 32'(bus1.voted_o), 32'h9);
    chk("l3_match.mismatch_o", 32'(bus1.mismatch_o), 32'd0);

    // Saturation of a 2-bit counter, then clear racing a mismatching sample.
    drv1(0, 0, 0, 0, 1);
    tick();
    repeat (5) begin
      drv1(1, 12'hFFF, 12'h066, 6'b111010, 0);
      tick();
    end
    drv1(0, 0, 0, 0, 0);
    tick();
    chk("t6.cnt_sat", 32'(bus1.err_cnt_o), 32'd3);
    drv1(1, 12'hFFF, 12'h066, 6'b111010, 0);
    tick();
    drv1(0, 0, 0, 0, 1);
    tick();
    drv1(0, 0, 0, 0, 0);
    chk("t6.clr_race.mismatch_o", 32'(bus1.mismatch_o), 32'd1);
    chk("t6.clr_race.cnt", 32'(bus1.err_cnt_o), 32'd0);
    chk("t6.clr_race.fault", 32'(bus1.fault_o), 32'd0);

    // Reset in the middle of a stream on both instances.
    drv0(1, 8'h33, 8'h54, 4'b0101, 0);
    drv1(1, 12'hFFF, 12'h066, 6'b111010, 0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t1.u0.valid_o", 32'(bus0.valid_o), 32'd0);
    chk("t1.u0.result_o", 32'(bus0.result_o), 32'd0);
    chk("t1.u0.mismatch_o", 32'(bus0.mismatch_o), 32'd0);
    chk("t1.u0.err_cnt_o", 32'(bus0.err_cnt_o), 32'd0);
    chk("t1.u1.voted_o", 32'(bus1.voted_o), 32'd0);
    chk("t1.u1.fault_o", 32'(bus1.fault_o), 32'd0);
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1.post_valid_1", 32'(bus0.valid_o), 32'd0);
    tick();
    chk("t1.post_valid_2", 32'(bus0.valid_o), 32'd0);
    drv0(1, 8'h99, 8'h88, 4'b0000, 0);
    tick();
    drv0(0, 0, 0, 0, 0);
    tick();
    chk("t1.first_valid", 32'(bus0.valid_o), 32'd1);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
